// File: rtl/sort_controller_if.sv
// Bundle between the bubble-sort controller, its host (start/done) and its datapath
// (status flags in, clr/ld/select/memory strobes out).
interface sort_controller_if #(
    parameter int DATAWIDTH = 32
);
    // Host handshake: start is a request level sampled only while busy=0; the
    // controller answers with busy for the whole sort and a single-cycle done
    // pulse in its last busy cycle. d_n must stay stable while busy=1.
    logic                 start;
    logic [DATAWIDTH-1:0] d_n;
    logic                 busy;
    logic                 done;

    logic c_lt_n_1;
    logic d_lt_n_c_1;
    logic t1_gt_t2;

    logic c_clr;
    logic c_ld;
    logic d_clr;
    logic d_ld;
    logic t1_clr;
    logic t1_ld;
    logic t2_clr;
    logic t2_ld;
    logic sel_add;
    logic sel_data;
    logic mem_rd;
    logic mem_wr;

    modport master (
        input  start, d_n, c_lt_n_1, d_lt_n_c_1, t1_gt_t2,
        output busy, done, c_clr, c_ld, d_clr, d_ld, t1_clr, t1_ld,
               t2_clr, t2_ld, sel_add, sel_data, mem_rd, mem_wr
    );

    modport slave (
        output start, d_n, c_lt_n_1, d_lt_n_c_1, t1_gt_t2,
        input  busy, done, c_clr, c_ld, d_clr, d_ld, t1_clr, t1_ld,
               t2_clr, t2_ld, sel_add, sel_data, mem_rd, mem_wr
    );
endinterface

// File: rtl/sort_controller.sv
// Moore FSM sequencing an in-place ascending bubble sort of mem[0..d_n-1]
// over an external counter/temp-register datapath.
module sort_controller #(
    parameter int DATAWIDTH = 32
) (
    input  logic                dp_clk,
    input  logic                rst_n,
    sort_controller_if.master   bus,
    output logic [3:0]          dbg_state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        INIT = 4'd1,
        OCHK = 4'd2,
        DCLR = 4'd3,
        ICHK = 4'd4,
        RD1  = 4'd5,
        LD1  = 4'd6,
        LD2  = 4'd7,
        CMP  = 4'd8,
        WR1  = 4'd9,
        WR2  = 4'd10,
        DINC = 4'd11,
        CINC = 4'd12,
        DONE = 4'd13
    } state_t;

    localparam logic [DATAWIDTH-1:0] MIN_N = DATAWIDTH'(2);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge dp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        bus.busy     = (state_q != IDLE);
        bus.done     = 1'b0;
        bus.c_clr    = 1'b0;
        bus.c_ld     = 1'b0;
        bus.d_clr    = 1'b0;
        bus.d_ld     = 1'b0;
        bus.t1_clr   = 1'b0;
        bus.t1_ld    = 1'b0;
        bus.t2_clr   = 1'b0;
        bus.t2_ld    = 1'b0;
        bus.sel_add  = 1'b0;
        bus.sel_data = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;

        case (state_q)
            IDLE: begin
                // Fewer than two elements skip the loops; n-1 would underflow at n=0.
                if (bus.start) begin
                    state_d = (bus.d_n < MIN_N) ? DONE : INIT;
                end
            end
            INIT: begin
                bus.c_clr  = 1'b1;
                bus.t1_clr = 1'b1;
                bus.t2_clr = 1'b1;
                state_d    = OCHK;
            end
            OCHK: state_d = bus.c_lt_n_1 ? DCLR : DONE;
            DCLR: begin
                bus.d_clr = 1'b1;
                state_d   = ICHK;
            end
            ICHK: state_d = bus.d_lt_n_c_1 ? RD1 : CINC;
            RD1: begin
                bus.mem_rd = 1'b1;
                state_d    = LD1;
            end
            LD1: begin
                // rdata from RD1 lands in t1 while the d+1 read is issued.
                bus.t1_ld   = 1'b1;
                bus.mem_rd  = 1'b1;
                bus.sel_add = 1'b1;
                state_d     = LD2;
            end
            LD2: begin
                bus.t2_ld = 1'b1;
                state_d   = CMP;
            end
            CMP: state_d = bus.t1_gt_t2 ? WR1 : DINC;
            WR1: begin
                bus.mem_wr   = 1'b1;
                bus.sel_data = 1'b1;
                state_d      = WR2;
            end
            WR2: begin
                bus.mem_wr  = 1'b1;
                bus.sel_add = 1'b1;
                state_d     = DINC;
            end
            DINC: begin
                bus.d_ld = 1'b1;
                state_d  = ICHK;
            end
            CINC: begin
                bus.c_ld = 1'b1;
                state_d  = OCHK;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sort_controller.sv
// Directed bench: the controller drives a behavioural counter/temp/memory datapath
// and each step is checked against hand-computed results and cycle counts.
module tb_sort_controller;

    logic        dp_clk;
    logic        rst_n;
    logic [3:0]  dbg_state;

    sort_controller_if #(.DATAWIDTH(32)) bus ();

    sort_controller #(.DATAWIDTH(32)) dut (
        .dp_clk    (dp_clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial dp_clk = 1'b0;
    always #5 dp_clk = ~dp_clk;

    // Datapath model: counters, temps, registered-read memory.
    logic [31:0] c_r, d_r, t1_r, t2_r, rdata_r, addr;
    logic [31:0] mem      [0:7];
    logic [31:0] init_mem [0:7];
    logic        load_req;

    assign addr           = bus.sel_add ? d_r + 32'd1 : d_r;
    assign bus.c_lt_n_1   = (c_r < bus.d_n - 32'd1);
    assign bus.d_lt_n_c_1 = (d_r < bus.d_n - c_r - 32'd1);
    assign bus.t1_gt_t2   = (t1_r > t2_r);

    always @(posedge dp_clk) begin
        if (bus.c_clr) c_r <= '0; else if (bus.c_ld) c_r <= c_r + 32'd1;
        if (bus.d_clr) d_r <= '0; else if (bus.d_ld) d_r <= d_r + 32'd1;
        if (bus.t1_clr) t1_r <= '0; else if (bus.t1_ld) t1_r <= rdata_r;
        if (bus.t2_clr) t2_r <= '0; else if (bus.t2_ld) t2_r <= rdata_r;
        if (bus.mem_rd) rdata_r <= mem[addr[2:0]];
        if (load_req) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_mem[i];
        end else if (bus.mem_wr) begin
            mem[addr[2:0]] <= bus.sel_data ? t2_r : t1_r;
        end
    end

    // Monitor: event counters and protocol violations, sampled mid-cycle.
    int rd_cnt, wr_cnt, done_cnt, swap_cnt, cinc_cnt, viol_cnt;
    logic [31:0] wr1_addr, wr1_data, wr2_addr, wr2_data;

    initial begin
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; swap_cnt = 0; cinc_cnt = 0; viol_cnt = 0;
        wr1_addr = '0; wr1_data = '0; wr2_addr = '0; wr2_data = '0;
    end

    always @(negedge dp_clk) begin
        if (bus.mem_rd) rd_cnt++;
        if (bus.mem_wr) wr_cnt++;
        if (bus.done) done_cnt++;
        if (bus.c_ld) cinc_cnt++;
        if (bus.mem_wr && !bus.sel_add) begin
            swap_cnt++;
            wr1_addr = addr;
            wr1_data = bus.sel_data ? t2_r : t1_r;
        end
        if (bus.mem_wr && bus.sel_add) begin
            wr2_addr = addr;
            wr2_data = bus.sel_data ? t2_r : t1_r;
        end
        if ((bus.mem_rd && bus.mem_wr) || (bus.c_clr && bus.c_ld) || (bus.d_clr && bus.d_ld) ||
            (bus.t1_clr && bus.t1_ld) || (bus.t2_clr && bus.t2_ld) || (bus.done && !bus.busy))
            viol_cnt++;
    end

    int n_asserts;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] v0, v1, v2, v3, v4);
        init_mem[0] = v0; init_mem[1] = v1; init_mem[2] = v2;
        init_mem[3] = v3; init_mem[4] = v4;
        for (int i = 5; i < 8; i++) init_mem[i] = '0;
        @(negedge dp_clk);
        load_req = 1'b1;
        @(negedge dp_clk);
        load_req = 1'b0;
    endtask

    // Returns the number of clock edges from the start-sampling edge to the
    // first cycle with done high, or -1 if the budget expires.
    task automatic run_sort(input logic [31:0] n, input bit repulse, output int cycles);
        bit seen;
        seen = 1'b0;
        @(negedge dp_clk);
        bus.d_n   = n;
        bus.start = 1'b1;
        cycles    = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge dp_clk);
            #1;
            cycles++;
            if (cycles == 1) bus.start = 1'b0;
            if (repulse && cycles == 5) bus.start = 1'b1;
            if (repulse && cycles == 6) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) cycles = -1;
    endtask

    task automatic check_idle_after(input string tag);
        @(posedge dp_clk);
        #1;
        chk({tag, "_done_width"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    endtask

    int cyc;
    int rd0, wr0, dn0, sw0, ci0;
    bit hit_wr1;

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        load_req  = 1'b0;
        bus.start = 1'b0;
        bus.d_n   = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge dp_clk);
        #1;
        chk("rst_state", {28'd0, dbg_state}, 32'd0);
        chk("rst_outputs", {16'd0, bus.busy, bus.done, bus.c_clr, bus.c_ld, bus.d_clr, bus.d_ld,
            bus.t1_clr, bus.t1_ld, bus.t2_clr, bus.t2_ld, bus.sel_add, bus.sel_data,
            bus.mem_rd, bus.mem_wr, 2'b00}, 32'd0);
        @(negedge dp_clk);
        rst_n = 1'b1;

        // n=0 and n=1 go straight to DONE.
        rd0 = rd_cnt; wr0 = wr_cnt;
        run_sort(32'd0, 1'b0, cyc);
        chk("n0_cycles", cyc, 32'd1);
        check_idle_after("n0");
        run_sort(32'd1, 1'b0, cyc);
        chk("n1_cycles", cyc, 32'd1);
        check_idle_after("n1");
        chk("n01_no_mem", rd_cnt - rd0 + wr_cnt - wr0, 32'd0);

        // n=2 already sorted.
        load_mem(32'd1, 32'd2, 32'd0, 32'd0, 32'd0);
        wr0 = wr_cnt;
        run_sort(32'd2, 1'b0, cyc);
        chk("n2s_cycles", cyc, 32'd13);
        check_idle_after("n2s");
        chk("n2s_mem0", mem[0], 32'd1);
        chk("n2s_mem1", mem[1], 32'd2);
        chk("n2s_no_wr", wr_cnt - wr0, 32'd0);

        // n=2 needing one swap.
        load_mem(32'd9, 32'd3, 32'd0, 32'd0, 32'd0);
        sw0 = swap_cnt;
        run_sort(32'd2, 1'b0, cyc);
        chk("n2w_cycles", cyc, 32'd15);
        check_idle_after("n2w");
        chk("n2w_swaps", swap_cnt - sw0, 32'd1);
        chk("n2w_wr1_addr", wr1_addr, 32'd0);
        chk("n2w_wr1_data", wr1_data, 32'd3);
        chk("n2w_wr2_addr", wr2_addr, 32'd1);
        chk("n2w_wr2_data", wr2_data, 32'd9);
        chk("n2w_mem0", mem[0], 32'd3);
        chk("n2w_mem1", mem[1], 32'd9);

        // Worst case, reverse ordered.
        load_mem(32'd5, 32'd4, 32'd3, 32'd2, 32'd1);
        sw0 = swap_cnt; ci0 = cinc_cnt;
        run_sort(32'd5, 1'b0, cyc);
        chk("n5_cycles", cyc, 32'd99);
        check_idle_after("n5");
        chk("n5_swaps", swap_cnt - sw0, 32'd10);
        chk("n5_outer", cinc_cnt - ci0, 32'd4);
        for (int i = 0; i < 5; i++) chk($sformatf("n5_mem%0d", i), mem[i], 32'(i + 1));

        // Duplicates and the unsigned extreme, with a stray start while busy.
        load_mem(32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0);
        dn0 = done_cnt; sw0 = swap_cnt;
        run_sort(32'd4, 1'b1, cyc);
        chk("n4_cycles", cyc, 32'd55);
        repeat (5) @(posedge dp_clk);
        #1;
        chk("n4_one_done", done_cnt - dn0, 32'd1);
        chk("n4_busy_end", {31'd0, bus.busy}, 32'd0);
        chk("n4_swaps", swap_cnt - sw0, 32'd2);
        chk("n4_mem0", mem[0], 32'd0);
        chk("n4_mem1", mem[1], 32'd7);
        chk("n4_mem2", mem[2], 32'd7);
        chk("n4_mem3", mem[3], 32'hFFFF_FFFF);

        // Reset asserted while WR1 is active.
        load_mem(32'd5, 32'd4, 32'd3, 32'd2, 32'd1);
        @(negedge dp_clk);
        bus.d_n   = 32'd5;
        bus.start = 1'b1;
        hit_wr1   = 1'b0;
        for (int k = 0; k < 200 && !hit_wr1; k++) begin
            @(posedge dp_clk);
            #1;
            bus.start = 1'b0;
            if (bus.mem_wr && !bus.sel_add) hit_wr1 = 1'b1;
        end
        chk("rstmid_reached_wr1", {31'd0, hit_wr1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_state", {28'd0, dbg_state}, 32'd0);
        chk("rstmid_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstmid_strobes", {20'd0, bus.c_clr, bus.c_ld, bus.d_clr, bus.d_ld, bus.t1_clr,
            bus.t1_ld, bus.t2_clr, bus.t2_ld, bus.sel_add, bus.sel_data, bus.mem_rd, bus.done}, 32'd0);
        @(posedge dp_clk);
        #1;
        chk("rstmid_hold", {28'd0, dbg_state}, 32'd0);
        @(negedge dp_clk);
        rst_n = 1'b1;
        repeat (2) @(posedge dp_clk);
        #1;
        chk("rstmid_stays_idle", {28'd0, dbg_state}, 32'd0);

        chk("protocol_violations", viol_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
